// File: rtl/demux_lane_buffer.sv
// Per-lane FIFO stage behind the demux: one producer writes the selected lane, and each
// lane drains independently through its own valid/ready handshake.
module demux_lane_buffer #(
    parameter int NUM_ELEM   = 6,
    parameter int ELEM_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic                                 in_valid_i,
    input  logic [$clog2(NUM_ELEM)-1:0]          in_sel_i,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  in_data_i,
    output logic                                 in_ready_o,
    output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  lane_data_o,
    output logic [NUM_ELEM-1:0]                  lane_valid_o,
    input  logic [NUM_ELEM-1:0]                  lane_ready_i,
    output logic                                 err_o,
    output logic                                 busy_o
);

    localparam int SEL_W = $clog2(NUM_ELEM);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                sel_oob;
    logic [NUM_ELEM-1:0] lane_full;
    logic                err_reg;

    // A selector past the last lane is always accepted so the demux never stalls on it.
    assign sel_oob = ({1'b0, in_sel_i} >= (SEL_W + 1)'(NUM_ELEM));

    always_comb begin
        in_ready_o = 1'b1;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (!sel_oob && in_sel_i == SEL_W'(k)) begin
                in_ready_o = ~lane_full[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= in_valid_i && sel_oob;
        end
    end

    assign err_o  = err_reg;
    assign busy_o = |lane_valid_o;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEM; gi++) begin : g_lane
            logic [ELEM_WIDTH-1:0] mem_reg [DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
            logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
            logic [CNT_W-1:0]      count_reg, count_next;
            logic                  push, pop;

            assign lane_full[gi]    = (count_reg == CNT_W'(DEPTH));
            assign lane_valid_o[gi] = (count_reg != '0);
            assign lane_data_o[gi]  = mem_reg[rd_ptr_reg];

            // Fullness is judged before this cycle's pop, so a full lane refuses even when draining.
            assign push = in_valid_i && !sel_oob && (in_sel_i == SEL_W'(gi)) && !lane_full[gi];
            assign pop  = lane_valid_o[gi] && lane_ready_i[gi];

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                count_next  = count_reg;
                if (push) begin
                    wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_next = count_reg + 1'b1;
                    2'b01:   count_next = count_reg - 1'b1;
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk_i or negedge arst_ni) begin
                if (!arst_ni) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                    if (push) begin
                        mem_reg[wr_ptr_reg] <= in_data_i[gi];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_demux_lane_buffer.sv
// Randomized and directed checks of demux_lane_buffer against per-lane queue model.
module tb_demux_lane_buffer;

    localparam int NUM_ELEM   = 6;
    localparam int ELEM_WIDTH = 8;
    localparam int DEPTH      = 2;

    logic                                clk_i = 1'b0;
    logic                                arst_ni = 1'b0;
    logic                                in_valid_i = 1'b0;
    logic [2:0]                          in_sel_i = '0;
    logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] in_data_i = '0;
    logic                                in_ready_o;
    logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] lane_data_o;
    logic [NUM_ELEM-1:0]                 lane_valid_o;
    logic [NUM_ELEM-1:0]                 lane_ready_i = '0;
    logic                                err_o;
    logic                                busy_o;

    demux_lane_buffer #(
        .NUM_ELEM  (NUM_ELEM),
        .ELEM_WIDTH(ELEM_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .in_valid_i  (in_valid_i),
        .in_sel_i    (in_sel_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .lane_data_o (lane_data_o),
        .lane_valid_o(lane_valid_o),
        .lane_ready_i(lane_ready_i),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] q [NUM_ELEM][$];
    logic       err_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_ELEM-1:0] model_valid();
        logic [NUM_ELEM-1:0] v;
        for (int k = 0; k < NUM_ELEM; k++) v[k] = (q[k].size() > 0);
        return v;
    endfunction

    function automatic logic model_ready(input logic [2:0] s);
        if (s >= NUM_ELEM) return 1'b1;
        return q[s].size() < DEPTH;
    endfunction

    // One clock cycle: drive at negedge, check pre-edge outputs, advance model to the edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [7:0] d,
                        input logic [NUM_ELEM-1:0] r);
        logic [63:0] rnd;
        logic        rdy;
        logic [NUM_ELEM-1:0] mv;
        @(negedge clk_i);
        rnd = {$urandom, $urandom};
        in_data_i = 48'(rnd);
        if (s < NUM_ELEM) in_data_i[s] = d;
        in_valid_i   = v;
        in_sel_i     = s;
        lane_ready_i = r;
        #1;
        mv  = model_valid();
        rdy = model_ready(s);
        chk("lane_valid", 64'(lane_valid_o), 64'(mv));
        chk("in_ready", 64'(in_ready_o), 64'(rdy));
        chk("busy", 64'(busy_o), 64'(|mv));
        chk("err", 64'(err_o), 64'(err_exp));
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (mv[k]) chk($sformatf("lane_data%0d", k), 64'(lane_data_o[k]), 64'(q[k][0]));
        end
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (mv[k] && r[k]) void'(q[k].pop_front());
        end
        if (v && rdy && s < NUM_ELEM) q[s].push_back(d);
        err_exp = v && (s >= NUM_ELEM);
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (q[k].size() > DEPTH) chk($sformatf("overflow%0d", k), 64'(q[k].size()), 64'(DEPTH));
        end
    endtask

    task automatic mid_reset();
        @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1;
        chk("rst_valid", 64'(lane_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_data", 64'(lane_data_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        for (int k = 0; k < NUM_ELEM; k++) q[k].delete();
        err_exp = 1'b0;
        in_valid_i   = 1'b0;
        lane_ready_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    initial begin
        // Power-on reset held for 100 ns
        #100;
        chk("por_valid", 64'(lane_valid_o), 64'd0);
        chk("por_data", 64'(lane_data_o), 64'd0);
        chk("por_err", 64'(err_o), 64'd0);
        chk("por_busy", 64'(busy_o), 64'd0);
        for (int s = 0; s < NUM_ELEM; s++) begin
            in_sel_i = 3'(s);
            #1 chk($sformatf("por_ready%0d", s), 64'(in_ready_o), 64'd1);
        end
        @(negedge clk_i);
        arst_ni = 1'b1;

        // Fill lane 3 to full
        step(1'b1, 3'd3, 8'hA5, '0);
        @(posedge clk_i); #1;
        chk("dir_valid3", 64'(lane_valid_o), 64'h08);
        chk("dir_data3", 64'(lane_data_o[3]), 64'hA5);
        step(1'b1, 3'd3, 8'h5A, '0);
        step(1'b0, 3'd3, 8'h00, '0);
        chk("dir_full3", 64'(in_ready_o), 64'd0);
        step(1'b1, 3'd3, 8'hFF, 6'b001000);   // refused: full even though popping
        step(1'b0, 3'd2, 8'h00, '0);
        chk("dir_ready2", 64'(in_ready_o), 64'd1);
        // Drain lane 3, then extra ready on empty lane
        step(1'b0, 3'd2, 8'h00, 6'b001000);
        step(1'b0, 3'd2, 8'h00, 6'b001000);
        step(1'b0, 3'd2, 8'h00, 6'b001000);
        step(1'b0, 3'd2, 8'h00, 6'b001000);
        chk("dir_empty3", 64'(lane_valid_o[3]), 64'd0);

        // Lane 0 at count 1 with push+pop for 10 cycles
        step(1'b1, 3'd0, 8'h00, '0);
        for (int i = 1; i <= 10; i++) step(1'b1, 3'd0, 8'(i), 6'b000001);
        step(1'b0, 3'd0, 8'h00, '0);
        chk("pp_valid0", 64'(lane_valid_o[0]), 64'd1);
        chk("pp_data0", 64'(lane_data_o[0]), 64'd10);
        step(1'b0, 3'd0, 8'h00, 6'b000001);

        // Out-of-range selectors
        step(1'b1, 3'd6, 8'h11, '0);
        step(1'b0, 3'd0, 8'h00, '0);
        chk("oob6_err", 64'(err_o), 64'd1);
        step(1'b1, 3'd7, 8'h22, '0);
        step(1'b0, 3'd0, 8'h00, '0);
        step(1'b0, 3'd0, 8'h00, '0);
        chk("oob_err_clear", 64'(err_o), 64'd0);

        // Random traffic with a mid-run reset
        for (int c = 0; c < 1000; c++) begin
            if (c == 500) mid_reset();
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 6'($urandom & $urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
